reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/rst_sync_chain.sv | 27 ++
 rtl/reset_sequencer.sv | 104 ++++++++++
 tb/tb_reset_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// Holds the state encoding and the counter-width helper.
package reset_seq_pkg;

  localparam int STATE_W         = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STEP_CYCLES = 4;

  typedef enum logic [STATE_W-1:0] {
    S_ASSERT  = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } seq_state_e;

  function automatic int cnt_width(int hold, int step, int nch);
    int m;
    m = hold;
    if (step * (nch - 1) > m) m = step * (nch - 1);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: async assert, sync deassert.
// A chain of flops with a constant 1 shifted in.
module rst_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  output logic RST_SYNC_N
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign RST_SYNC_N = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds, then releases channel resets
// one by one in index order; SW_RST restarts the sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST,
  output logic               RST_SYNC_N,
  output logic [NUM_CH-1:0]  CH_RST_N,
  output logic               SEQ_DONE,
  output logic [STATE_W-1:0] STATE
);

  localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES, NUM_CH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;

  rst_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .RST_SYNC_N (RST_SYNC_N)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    done_d  = done_q;
    unique case (state_q)
      S_ASSERT: begin
        cnt_d  = '0;
        ch_d   = '0;
        done_d = 1'b0;
        if (RST_SYNC_N && !SW_RST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          ch_d    = NUM_CH'(1);
          done_d  = ch_d[NUM_CH-1];
          state_d = done_d ? S_RUN : S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        // Channels form a thermometer code: shift in the next 1.
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          ch_d    = (ch_q << 1) | NUM_CH'(1);
          done_d  = ch_d[NUM_CH-1];
          state_d = done_d ? S_RUN : S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_ASSERT;
      end
    endcase
    // Reset events override any release on the same edge.
    if (!RST_SYNC_N || SW_RST) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      ch_d    = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  assign CH_RST_N = ch_q;
  assign SEQ_DONE = done_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default build
// plus a 3-stage / 1-channel / hold-1 build.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sw  = 1'b0;
  logic sw1 = 1'b0;

  logic               sync0, done0;
  logic [3:0]         ch0;
  logic [STATE_W-1:0] st0;
  logic               sync1, done1;
  logic [0:0]         ch1;
  logic [STATE_W-1:0] st1;

  always #5 clk = ~clk;

  reset_sequencer u_dut0 (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST     (sw),
    .RST_SYNC_N (sync0),
    .CH_RST_N   (ch0),
    .SEQ_DONE   (done0),
    .STATE      (st0)
  );

  reset_sequencer #(
    .SYNC_STAGES (3),
    .NUM_CH      (1),
    .HOLD_CYCLES (1),
    .STEP_CYCLES (4)
  ) u_dut1 (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST     (sw1),
    .RST_SYNC_N (sync1),
    .CH_RST_N   (ch1),
    .SEQ_DONE   (done1),
    .STATE      (st1)
  );

  typedef struct {
    string      tag;
    int         inst;
    int         edge_n;
    logic       sync;
    logic [3:0] ch;
    logic       done;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cmp(exp_t e);
    if (e.inst == 0) begin
      chk({e.tag, ".sync"}, 32'(sync0), 32'(e.sync));
      chk({e.tag, ".ch"},   32'(ch0),   32'(e.ch));
      chk({e.tag, ".done"}, 32'(done0), 32'(e.done));
      chk({e.tag, ".st"},   32'(st0),   32'(e.st));
    end else begin
      chk({e.tag, ".sync1"}, 32'(sync1), 32'(e.sync));
      chk({e.tag, ".ch1"},   32'(ch1),   32'(e.ch));
      chk({e.tag, ".done1"}, 32'(done1), 32'(e.done));
      chk({e.tag, ".st1"},   32'(st1),   32'(e.st));
    end
  endtask

  function automatic exp_t mk(string tag, int inst, int e,
                              logic s, logic [3:0] c,
                              logic d, logic [1:0] st);
    exp_t x;
    x.tag = tag; x.inst = inst; x.edge_n = e;
    x.sync = s; x.ch = c; x.done = d; x.st = st;
    return x;
  endfunction

  task automatic push(string tag, int inst, int e, logic s,
                      logic [3:0] c, logic d, logic [1:0] st);
    sb.push_back(mk(tag, inst, e, s, c, d, st));
  endtask

  task automatic now_zero(string tag);
    cmp(mk({tag, "0"}, 0, 0, 1'b0, 4'h0, 1'b0, 2'd0));
    cmp(mk({tag, "1"}, 1, 0, 1'b0, 4'h0, 1'b0, 2'd0));
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    edge_cnt++;
    while (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
      e = sb.pop_front();
      cmp(e);
    end
  endtask

  // Power-on timeline for both builds, edges counted from RST rise.
  task automatic push_po(int last);
    push("po_e1",  0, 1,  1'b0, 4'h0, 1'b0, 2'd0);
    push("po_e2",  0, 2,  1'b1, 4'h0, 1'b0, 2'd0);
    push("p1_e2",  1, 2,  1'b0, 4'h0, 1'b0, 2'd0);
    push("po_e3",  0, 3,  1'b1, 4'h0, 1'b0, 2'd1);
    push("p1_e3",  1, 3,  1'b1, 4'h0, 1'b0, 2'd0);
    push("p1_e4",  1, 4,  1'b1, 4'h0, 1'b0, 2'd1);
    push("p1_e5",  1, 5,  1'b1, 4'h1, 1'b1, 2'd3);
    push("p1_e8",  1, 8,  1'b1, 4'h1, 1'b1, 2'd3);
    push("po_e18", 0, 18, 1'b1, 4'h0, 1'b0, 2'd1);
    push("po_e19", 0, 19, 1'b1, 4'h1, 1'b0, 2'd2);
    push("po_e22", 0, 22, 1'b1, 4'h1, 1'b0, 2'd2);
    push("po_e23", 0, 23, 1'b1, 4'h3, 1'b0, 2'd2);
    push("po_e24", 0, 24, 1'b1, 4'h3, 1'b0, 2'd2);
    if (last >= 27) push("po_e27", 0, 27, 1'b1, 4'h7, 1'b0, 2'd2);
    if (last >= 30) push("po_e30", 0, 30, 1'b1, 4'h7, 1'b0, 2'd2);
    if (last >= 31) push("po_e31", 0, 31, 1'b1, 4'hF, 1'b1, 2'd3);
  endtask

  task automatic rst_rise();
    #2 rst = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 now_zero("por");

    // Power-on sequence
    repeat (5) @(posedge clk);
    rst_rise();
    push_po(31);
    push("run_e34", 0, 34, 1'b1, 4'hF, 1'b1, 2'd3);
    repeat (34) step();

    // Software reset in S_RUN for three sampled edges
    edge_cnt = 0;
    sw = 1'b1;
    push("sw_e1",  0, 1,  1'b1, 4'h0, 1'b0, 2'd0);
    push("sw_e2",  0, 2,  1'b1, 4'h0, 1'b0, 2'd0);
    push("sw_i1",  1, 2,  1'b1, 4'h1, 1'b1, 2'd3);
    push("sw_e3",  0, 3,  1'b1, 4'h0, 1'b0, 2'd0);
    push("sw_e4",  0, 4,  1'b1, 4'h0, 1'b0, 2'd1);
    push("sw_e19", 0, 19, 1'b1, 4'h0, 1'b0, 2'd1);
    push("sw_e20", 0, 20, 1'b1, 4'h1, 1'b0, 2'd2);
    push("sw_e32", 0, 32, 1'b1, 4'hF, 1'b1, 2'd3);
    repeat (3) step();
    sw = 1'b0;
    repeat (29) step();

    // Async reset from S_RUN, then collision of SW_RST with last release
    #1 rst = 1'b0;
    #1 now_zero("run_abort");
    repeat (3) @(posedge clk);
    rst_rise();
    push_po(30);
    push("col_e31", 0, 31, 1'b1, 4'h0, 1'b0, 2'd0);
    push("col_e32", 0, 32, 1'b1, 4'h0, 1'b0, 2'd1);
    repeat (30) step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    step();

    // Async abort 2 ns after edge 24, mid-release
    rst = 1'b0;
    repeat (2) @(posedge clk);
    rst_rise();
    push_po(24);
    repeat (24) step();
    #1 rst = 1'b0;
    #1 now_zero("abort");
    repeat (4) @(posedge clk);
    rst_rise();
    push_po(31);
    repeat (31) step();

    // 1 ns glitch on RST between edges
    repeat (3) step();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    edge_cnt = 0;
    #1 now_zero("glitch");
    push_po(31);
    repeat (31) step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
